bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter_if.sv | 48 ++++
 rtl/bram_port_arbiter.sv | 117 +++++++++++
 tb/tb_bram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Requester, response and RAM-port bundle for bram_port_arbiter.
// master = requesters plus RAM model side, slave = the arbiter.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [DATA_W-1:0] ram_di;
  logic              ram_rden;
  logic [ADDR_W-1:0] ram_rdaddr;
  logic [DATA_W-1:0] ram_do;
  logic              busy;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output ram_do,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  ram_wren, ram_wraddr, ram_di, ram_rden, ram_rdaddr,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  ram_do,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output ram_wren, ram_wraddr, ram_di, ram_rden, ram_rdaddr,
    output busy
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter onto a simple dual-port BRAM (one write + one read per cycle).
// Optional power-up zero sweep of the RAM when BRAM_ARB_CLEAR_EN is defined.
module bram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input logic               clk,
  input logic               rst,
  bram_port_arbiter_if.slave bus
);

`ifdef BRAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
`else
  typedef enum logic {ST_RUN} state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_prio;
  logic [1:0]        r_rsp_valid;
  logic [ADDR_W-1:0] r_rdaddr;
`ifdef BRAM_ARB_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_addr;
`endif

  logic [1:0]        w_wr_req;
  logic [1:0]        w_rd_req;
  logic              w_run;
  logic              w_wr_gnt;
  logic              w_rd_gnt;
  logic              w_wr_sel;
  logic              w_rd_sel;
  logic              w_conflict;
  logic [ADDR_W-1:0] w_rd_addr_win;

  // Write and read slots are arbitrated independently; sel=1 means requester 1 wins.
  always_comb begin
    w_wr_req      = {bus.req1_valid & bus.req1_we,  bus.req0_valid & bus.req0_we};
    w_rd_req      = {bus.req1_valid & ~bus.req1_we, bus.req0_valid & ~bus.req0_we};
    w_run         = (r_state == ST_RUN) && !rst;
    w_wr_gnt      = w_run && (|w_wr_req);
    w_rd_gnt      = w_run && (|w_rd_req);
    w_wr_sel      = (&w_wr_req) ? r_prio : w_wr_req[1];
    w_rd_sel      = (&w_rd_req) ? r_prio : w_rd_req[1];
    w_conflict    = (w_wr_gnt && (&w_wr_req)) || (w_rd_gnt && (&w_rd_req));
    w_rd_addr_win = w_rd_sel ? bus.req1_addr : bus.req0_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef BRAM_ARB_CLEAR_EN
      r_state <= ST_CLEAR;
`else
      r_state <= ST_RUN;
`endif
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef BRAM_ARB_CLEAR_EN
    if ((r_state == ST_CLEAR) && (r_clr_addr == '1)) w_state_nxt = ST_RUN;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      if (w_conflict) r_prio <= ~r_prio;
      r_rsp_valid <= {w_rd_gnt & w_rd_sel, w_rd_gnt & ~w_rd_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_gnt) r_rdaddr <= w_rd_addr_win;
  end

`ifdef BRAM_ARB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end
`endif

  // Responses are masked during reset so a read in flight at reset never surfaces.
  always_comb begin
    bus.req0_ready = (w_wr_gnt && !w_wr_sel) || (w_rd_gnt && !w_rd_sel);
    bus.req1_ready = (w_wr_gnt &&  w_wr_sel) || (w_rd_gnt &&  w_rd_sel);
    bus.ram_wren   = w_wr_gnt;
    bus.ram_wraddr = w_wr_sel ? bus.req1_addr  : bus.req0_addr;
    bus.ram_di     = w_wr_sel ? bus.req1_wdata : bus.req0_wdata;
    bus.ram_rden   = w_rd_gnt;
    bus.ram_rdaddr = w_rd_gnt ? w_rd_addr_win : r_rdaddr;
    bus.rsp0_valid = r_rsp_valid[0] && !rst;
    bus.rsp1_valid = r_rsp_valid[1] && !rst;
    bus.rsp0_rdata = bus.ram_do;
    bus.rsp1_rdata = bus.ram_do;
    bus.busy       = 1'b0;
`ifdef BRAM_ARB_CLEAR_EN
    if ((r_state == ST_CLEAR) && !rst) begin
      bus.ram_wren   = 1'b1;
      bus.ram_wraddr = r_clr_addr;
      bus.ram_di     = '0;
      bus.busy       = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed plus randomized bench for bram_port_arbiter against a list-based arbitration model.
// Exercises the BRAM_ARB_CLEAR_EN sweep when that macro is defined.
module tb_bram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;

  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Read-first synchronous RAM attached to the arbiter's ports
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.ram_rden) bus.ram_do <= ram[bus.ram_rdaddr];
    if (bus.ram_wren) ram[bus.ram_wraddr] <= bus.ram_di;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit            m_prio;
  bit            m_pv [2];
  logic [DW-1:0] m_pd [2];
  logic [AW-1:0] m_rdaddr;
  bit            m_rdaddr_ok;

  bit            v  [2];
  bit            we [2];
  logic [AW-1:0] a  [2];
  logic [DW-1:0] d  [2];
  bit            acc [2];

  int            last_wr_win;
  int            last_rd_win;
  logic          obs_ready [2];
  logic [DW-1:0] obs_rdata [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req0_valid = v[0];  bus.req0_we = we[0];  bus.req0_addr = a[0];  bus.req0_wdata = d[0];
    bus.req1_valid = v[1];  bus.req1_we = we[1];  bus.req1_addr = a[1];  bus.req1_wdata = d[1];
  endtask

  task automatic set_req(input int n, input bit valid, input bit w, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    v[n] = valid;  we[n] = w;  a[n] = addr;  d[n] = data;
  endtask

  task automatic idle();
    v[0] = 1'b0;
    v[1] = 1'b0;
  endtask

  task automatic rand_req(input int n);
    v[n]  = 1'($urandom_range(0, 3) != 0);
    we[n] = 1'($urandom_range(0, 1));
    a[n]  = AW'($urandom_range(0, 7));
    d[n]  = DW'($urandom);
  endtask

  // One RUN-mode (or reset) cycle: check the DUT against the rules, then advance the model.
  task automatic run_cycle(input bit rst_v);
    int wl[$];
    int rl[$];
    int ww;
    int rw;
    rst = rst_v;
    drive();
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      if (v[n] && we[n]) wl.push_back(n);
      else if (v[n])     rl.push_back(n);
    end
    ww = -1;
    rw = -1;
    if (!rst_v) begin
      if (wl.size() == 1) ww = wl[0]; else if (wl.size() == 2) ww = int'(m_prio);
      if (rl.size() == 1) rw = rl[0]; else if (rl.size() == 2) rw = int'(m_prio);
    end
    obs_ready[0] = bus.req0_ready;
    obs_ready[1] = bus.req1_ready;
    obs_rdata[0] = bus.rsp0_rdata;
    obs_rdata[1] = bus.rsp1_rdata;
    chk("ready0", 32'(bus.req0_ready), 32'((ww == 0) || (rw == 0)));
    chk("ready1", 32'(bus.req1_ready), 32'((ww == 1) || (rw == 1)));
    chk("ram_wren", 32'(bus.ram_wren), 32'(ww >= 0));
    if (ww >= 0) begin
      chk("ram_wraddr", 32'(bus.ram_wraddr), 32'(a[ww]));
      chk("ram_di", 32'(bus.ram_di), 32'(d[ww]));
    end
    chk("ram_rden", 32'(bus.ram_rden), 32'(rw >= 0));
    if (rw >= 0) chk("ram_rdaddr", 32'(bus.ram_rdaddr), 32'(a[rw]));
    else if (m_rdaddr_ok) chk("ram_rdaddr_hold", 32'(bus.ram_rdaddr), 32'(m_rdaddr));
    chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_pv[0] && !rst_v));
    chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_pv[1] && !rst_v));
    if (m_pv[0] && !rst_v) chk("rsp0_rdata", 32'(bus.rsp0_rdata), 32'(m_pd[0]));
    if (m_pv[1] && !rst_v) chk("rsp1_rdata", 32'(bus.rsp1_rdata), 32'(m_pd[1]));
    chk("busy_run", 32'(bus.busy), 32'd0);
    last_wr_win = ww;
    last_rd_win = rw;
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      acc[n]  = (ww == n) || (rw == n);
      m_pv[n] = (rw == n);
    end
    if (rst_v) begin
      m_prio = 1'b0;
    end else begin
      if (rw >= 0) begin
        m_pd[rw]    = ref_mem[a[rw]];
        m_rdaddr    = a[rw];
        m_rdaddr_ok = 1'b1;
      end
      if (ww >= 0) ref_mem[a[ww]] = d[ww];
      if (wl.size() == 2 || rl.size() == 2) m_prio = ~m_prio;
    end
  endtask

`ifdef BRAM_ARB_CLEAR_EN
  task automatic sweep(input int unsigned ncyc);
    for (int unsigned i = 0; i < ncyc; i++) begin
      rst = 1'b0;
      rand_req(0);
      rand_req(1);
      drive();
      @(negedge clk);
      chk("clr_busy", 32'(bus.busy), 32'd1);
      chk("clr_ready0", 32'(bus.req0_ready), 32'd0);
      chk("clr_ready1", 32'(bus.req1_ready), 32'd0);
      chk("clr_wren", 32'(bus.ram_wren), 32'd1);
      chk("clr_wraddr", 32'(bus.ram_wraddr), i);
      chk("clr_di", 32'(bus.ram_di), 32'd0);
      chk("clr_rden", 32'(bus.ram_rden), 32'd0);
      chk("clr_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
      @(posedge clk);
      #1;
      ref_mem[i] = '0;
    end
    m_pv[0] = 1'b0;
    m_pv[1] = 1'b0;
    idle();
  endtask
`endif

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      rand_req(0);
      rand_req(1);
      run_cycle(1'b1);
    end
    idle();
`ifdef BRAM_ARB_CLEAR_EN
    sweep(DEPTH);
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    m_prio = 1'b0;  m_pv[0] = 1'b0;  m_pv[1] = 1'b0;  m_rdaddr_ok = 1'b0;
    for (int n = 0; n < 2; n++) begin
      set_req(n, 1'b0, 1'b0, '0, '0);
      acc[n] = 1'b0;
    end
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;

`ifdef BRAM_ARB_CLEAR_EN
    // Interrupted sweep: the sweep after the second reset must start over at address 0
    for (int i = 0; i < 2; i++) run_cycle(1'b1);
    sweep(500);
`endif
    do_reset();

    // Write addr 5 then read it back on requester 0
    set_req(0, 1'b1, 1'b1, AW'(5), 16'hA5A5);
    run_cycle(1'b0);
    set_req(0, 1'b1, 1'b0, AW'(5), '0);
    run_cycle(1'b0);
    idle();
    run_cycle(1'b0);
    chk("req033_rdata", 32'(obs_rdata[0]), 32'h0000_A5A5);

    // Both read continuously from reset: grants alternate 0,1,0,1
    do_reset();
    set_req(0, 1'b1, 1'b0, AW'(1), '0);
    set_req(1, 1'b1, 1'b0, AW'(2), '0);
    for (int unsigned k = 0; k < 4; k++) begin
      run_cycle(1'b0);
      chk("req034_grant", 32'(last_rd_win), 32'(k % 2));
    end
    idle();
    run_cycle(1'b0);

    // Same-address write and read in one cycle: read sees old data
    set_req(0, 1'b1, 1'b1, AW'(3), 16'h1234);
    set_req(1, 1'b1, 1'b0, AW'(3), '0);
    run_cycle(1'b0);
    chk("req035_ready0", 32'(obs_ready[0]), 32'd1);
    chk("req035_ready1", 32'(obs_ready[1]), 32'd1);
    idle();
    run_cycle(1'b0);
    set_req(1, 1'b1, 1'b0, AW'(3), '0);
    run_cycle(1'b0);
    idle();
    run_cycle(1'b0);
    chk("req035_newdata", 32'(obs_rdata[1]), 32'h0000_1234);

    // Reset right after a read grant, with prio set to 1 beforehand
    set_req(0, 1'b1, 1'b0, AW'(6), '0);
    set_req(1, 1'b1, 1'b0, AW'(7), '0);
    run_cycle(1'b0);
    if (!m_prio) run_cycle(1'b0);
    idle();
    set_req(0, 1'b1, 1'b0, AW'(5), '0);
    run_cycle(1'b0);
    do_reset();
    set_req(0, 1'b1, 1'b1, AW'(8), 16'h0BEE);
    set_req(1, 1'b1, 1'b1, AW'(9), 16'h0CAF);
    run_cycle(1'b0);
    chk("req036_prio_after_rst", 32'(last_wr_win), 32'd0);
    idle();
    run_cycle(1'b0);

`ifdef BRAM_ARB_CLEAR_EN
    // Top address was zeroed by the sweep (bench RAM held random data before)
    do_reset();
    set_req(1, 1'b1, 1'b0, AW'(DEPTH - 1), '0);
    run_cycle(1'b0);
    idle();
    run_cycle(1'b0);
    chk("req037_top_zero", 32'(obs_rdata[1]), 32'd0);
`endif

    // Randomized traffic; each requester holds its request until accepted
    acc[0] = 1'b1;
    acc[1] = 1'b1;
    for (int unsigned c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) if (!v[n] || acc[n]) rand_req(n);
      run_cycle(1'b0);
    end
    idle();
    run_cycle(1'b0);
    run_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
